// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Producer side of the instruction interface. Fetches one 16-bit word (two
// words for MOV immediate / MOV direct) from program memory over a req/ack
// handshake, presents it to the control unit with a one-cycle reset_cycle
// pulse, then waits for instr_done before advancing or branching.
//
// Build option:
//   FETCH_TIMEOUT_EN  - when defined, a request left unacknowledged for
//                       TIMEOUT consecutive cycles aborts the fetch, sets the
//                       sticky fetch_fault flag and parks the unit in FAULT
//                       until reset. When undefined, fetches wait forever and
//                       fetch_fault is tied low.
//
// The MOV opcode comes from the `MOV macro (5 bits); a default is supplied
// below if the surrounding build does not define it.
//
// Ports:
//   clk          in   system clock, posedge
//   reset_n      in   synchronous active-low reset
//   mem_req      out  memory read request
//   mem_addr     out  read address (equals pc while mem_req=1)
//   mem_rdata    in   read data, valid with mem_ack
//   mem_ack      in   read acknowledge, one cycle per request
//   instr_done   in   control unit finished the current instruction
//   branch_en    in   redirect pc to branch_addr (sampled with instr_done)
//   branch_addr  in   branch target
//   halt         in   suppress new fetches (sampled in IDLE only)
//   instruction  out  current instruction word
//   operand      out  second word of two-word instructions, otherwise 0
//   instr_valid  out  instruction/operand valid and stable
//   reset_cycle  out  one-cycle pulse at issue
//   pc           out  address of the next word to fetch
//   fetch_fault  out  sticky fetch timeout flag
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for halt=0 to start a fetch
// S_FETCH_I | requesting the instruction word
// S_FETCH_O | requesting the operand word (req re-raised after a gap)
// S_ISSUE   | single cycle: reset_cycle=1, instr_valid=1
// S_EXEC    | holding the instruction until instr_done
// S_FAULT   | fetch timed out; parked until reset (timeout build only)
// ---------------------------------------------------------------------------
`ifndef MOV
`define MOV 5'b00100
`endif

module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  input  logic              instr_done,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              halt,
  output logic [15:0]       instruction,
  output logic [15:0]       operand,
  output logic              instr_valid,
  output logic              reset_cycle,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_I,
    S_FETCH_O,
    S_ISSUE,
    S_EXEC
`ifdef FETCH_TIMEOUT_EN
    , S_FAULT
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_d;
  logic [15:0]       instruction_d, operand_d;
  logic              instr_valid_d, reset_cycle_d, mem_req_d;
  logic              ack_ok, two_word;

  // pc is a plain register, so mem_addr stays a registered output.
  assign mem_addr = pc;
  assign ack_ok   = mem_req && mem_ack;
  assign two_word = (mem_rdata[15:11] == `MOV) &&
                    ((mem_rdata[10:8] == 3'b001) || (mem_rdata[10:8] == 3'b011));

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          fetch_fault_d;
`else
  localparam int unused_timeout = TIMEOUT;
  assign fetch_fault = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc;
    instruction_d = instruction;
    operand_d     = operand;
    instr_valid_d = instr_valid;
    reset_cycle_d = 1'b0;
    mem_req_d     = mem_req;
`ifdef FETCH_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    fetch_fault_d = fetch_fault;
`endif

    case (state_q)
      S_IDLE: begin
        if (!halt) begin
          state_d   = S_FETCH_I;
          mem_req_d = 1'b1;
        end
      end
      S_FETCH_I: begin
        if (ack_ok) begin
          instruction_d = mem_rdata;
          pc_d          = pc + ADDR_W'(1);
          mem_req_d     = 1'b0;
          if (two_word) begin
            state_d = S_FETCH_O;
          end else begin
            operand_d     = '0;
            state_d       = S_ISSUE;
            reset_cycle_d = 1'b1;
            instr_valid_d = 1'b1;
          end
        end
      end
      S_FETCH_O: begin
        if (ack_ok) begin
          operand_d     = mem_rdata;
          pc_d          = pc + ADDR_W'(1);
          mem_req_d     = 1'b0;
          state_d       = S_ISSUE;
          reset_cycle_d = 1'b1;
          instr_valid_d = 1'b1;
        end else if (!mem_req) begin
          // first FETCH_O cycle runs with req low, guaranteeing a gap
          mem_req_d = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (instr_done) begin
          instr_valid_d = 1'b0;
          if (branch_en) pc_d = branch_addr;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

`ifdef FETCH_TIMEOUT_EN
    // Down-counter: loaded when a request is raised, terminal count at zero
    // means TIMEOUT request cycles have gone by without an ack.
    if (!mem_req && mem_req_d) begin
      to_cnt_d = TW'(TIMEOUT - 1);
    end else if (mem_req && !mem_ack) begin
      if (to_cnt_q == '0) begin
        mem_req_d     = 1'b0;
        fetch_fault_d = 1'b1;
        instr_valid_d = 1'b0;
        state_d       = S_FAULT;
      end else begin
        to_cnt_d = to_cnt_q - TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pc          <= RESET_PC;
      instruction <= '0;
      operand     <= '0;
      instr_valid <= 1'b0;
      reset_cycle <= 1'b0;
      mem_req     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      to_cnt_q    <= '0;
      fetch_fault <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc          <= pc_d;
      instruction <= instruction_d;
      operand     <= operand_d;
      instr_valid <= instr_valid_d;
      reset_cycle <= reset_cycle_d;
      mem_req     <= mem_req_d;
`ifdef FETCH_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      fetch_fault <= fetch_fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Scoreboard bench for instr_fetch_unit. The stimulus thread pushes the
// expected request addresses and expected issued instructions into queues;
// a memory responder and an issue monitor pop and compare whenever the DUT
// presents a request acknowledge or a reset_cycle pulse.
// ---------------------------------------------------------------------------
`ifndef MOV
`define MOV 5'b00100
`endif

module tb_instr_fetch_unit;

  localparam int TO = 15;

  localparam logic [15:0] MOV_REG = {5'(`MOV), 3'b010, 8'h55};
  localparam logic [15:0] MOV_IMM = {5'(`MOV), 3'b001, 8'h00};
  localparam logic [15:0] MOV_DIR = {5'(`MOV), 3'b011, 8'h07};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        instr_done;
  logic        branch_en;
  logic [15:0] branch_addr;
  logic        halt;
  logic [15:0] instruction;
  logic [15:0] operand;
  logic        instr_valid;
  logic        reset_cycle;
  logic [15:0] pc;
  logic        fetch_fault;

  instr_fetch_unit #(
    .ADDR_W  (16),
    .RESET_PC(16'h0000),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .instr_done (instr_done),
    .branch_en  (branch_en),
    .branch_addr(branch_addr),
    .halt       (halt),
    .instruction(instruction),
    .operand    (operand),
    .instr_valid(instr_valid),
    .reset_cycle(reset_cycle),
    .pc         (pc),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] addr_q[$];
  logic [47:0] iss_q[$];   // {instruction, operand, pc}

  int lat = 0;
  bit ack_en = 1'b1;
  bit force_ack = 1'b0;
  int wait_cnt = 0;
  int req_rises = 0;
  int pulses = 0;
  bit prev_req = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // memory responder: acks after 'lat' wait cycles, checks request address
  always @(negedge clk) begin
    if (mem_req && !prev_req) req_rises++;
    prev_req = mem_req;
    if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = 16'hFFFF;
    end else if (mem_req && ack_en && wait_cnt == lat) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr];
      if (addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_unexpected addr=%h", mem_addr);
      end else begin
        check("req_addr", {16'h0, mem_addr}, {16'h0, addr_q.pop_front()});
      end
    end else begin
      mem_ack = 1'b0;
    end
    wait_cnt = mem_req ? wait_cnt + 1 : 0;
  end

  // issue monitor
  always @(negedge clk) begin
    logic [47:0] e;
    if (reset_cycle) begin
      pulses++;
      if (iss_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue_unexpected instruction=%h", instruction);
      end else begin
        e = iss_q.pop_front();
        check("issue_instruction", {16'h0, instruction}, {16'h0, e[47:32]});
        check("issue_operand", {16'h0, operand}, {16'h0, e[31:16]});
        check("issue_pc", {16'h0, pc}, {16'h0, e[15:0]});
        check("issue_valid", {31'h0, instr_valid}, 32'd1);
      end
    end
  end

  task automatic wait_exec();
    int n = 0;
    while (!(instr_valid && !reset_cycle) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL wait_exec timeout instr_valid=%b", instr_valid);
    end
  endtask

  task automatic run_instr(input int lat_v, input bit brn, input logic [15:0] ba,
                           input logic [15:0] exp_pc);
    lat  = lat_v;
    halt = 1'b0;
    @(negedge clk);
    halt = 1'b1;
    wait_exec();
    repeat (2) @(negedge clk);
    check("exec_hold_valid", {31'h0, instr_valid}, 32'd1);
    instr_done  = 1'b1;
    branch_en   = brn;
    branch_addr = ba;
    @(negedge clk);
    instr_done = 1'b0;
    branch_en  = 1'b0;
    check("done_valid_low", {31'h0, instr_valid}, 32'd0);
    check("done_pc", {16'h0, pc}, {16'h0, exp_pc});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, p0, n;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h0800;
    mem[16'h0040] = MOV_REG;
    mem[16'h0004] = MOV_IMM;
    mem[16'h0005] = 16'hBEEF;
    mem[16'h0006] = 16'h1234;
    mem[16'hFFFF] = MOV_DIR;

    reset_n = 1'b0; halt = 1'b0; instr_done = 1'b0; branch_en = 1'b0;
    branch_addr = 16'h0; mem_ack = 1'b0; mem_rdata = 16'h0;
    lat = 0; ack_en = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_mem_req", {31'h0, mem_req}, 32'd0);
    check("rst_pc", {16'h0, pc}, 32'd0);
    check("rst_instruction", {16'h0, instruction}, 32'd0);
    check("rst_operand", {16'h0, operand}, 32'd0);
    check("rst_valid", {31'h0, instr_valid}, 32'd0);
    check("rst_reset_cycle", {31'h0, reset_cycle}, 32'd0);
    check("rst_fault", {31'h0, fetch_fault}, 32'd0);

    // single word, zero-wait, exact latency
    addr_q.push_back(16'h0000);
    iss_q.push_back({16'h0800, 16'h0000, 16'h0001});
    reset_n = 1'b1;
    @(negedge clk);
    check("c1_req", {31'h0, mem_req}, 32'd1);
    check("c1_addr", {16'h0, mem_addr}, 32'd0);
    @(negedge clk);
    check("c2_reset_cycle", {31'h0, reset_cycle}, 32'd1);
    check("c2_req_low", {31'h0, mem_req}, 32'd0);
    halt = 1'b1;
    @(negedge clk);
    check("c3_reset_cycle", {31'h0, reset_cycle}, 32'd0);
    check("c3_valid", {31'h0, instr_valid}, 32'd1);
    branch_en = 1'b1; branch_addr = 16'h1234;
    repeat (2) @(negedge clk);
    check("branch_no_done_valid", {31'h0, instr_valid}, 32'd1);
    check("branch_no_done_pc", {16'h0, pc}, 32'h1);
    instr_done = 1'b1; branch_addr = 16'h0040;
    @(negedge clk);
    instr_done = 1'b0; branch_en = 1'b0;
    check("branch_valid_low", {31'h0, instr_valid}, 32'd0);
    check("branch_pc", {16'h0, pc}, 32'h40);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("halt_no_req", {31'h0, mem_req}, 32'd0);
    end

    // MOV register: single fetch
    addr_q.push_back(16'h0040);
    iss_q.push_back({MOV_REG, 16'h0000, 16'h0041});
    run_instr(0, 1'b1, 16'h0004, 16'h0004);

    // MOV immediate, 3-cycle ack latency
    r0 = req_rises; p0 = pulses;
    addr_q.push_back(16'h0004);
    addr_q.push_back(16'h0005);
    iss_q.push_back({MOV_IMM, 16'hBEEF, 16'h0006});
    run_instr(3, 1'b0, 16'h0000, 16'h0006);
    check("movimm_two_requests", req_rises - r0, 32'd2);
    check("movimm_one_pulse", pulses - p0, 32'd1);

    // single word with wait states
    addr_q.push_back(16'h0006);
    iss_q.push_back({16'h1234, 16'h0000, 16'h0007});
    run_instr(2, 1'b1, 16'hFFFF, 16'hFFFF);

    // MOV direct at FFFF: pc wraps, operand from address 0
    addr_q.push_back(16'hFFFF);
    addr_q.push_back(16'h0000);
    iss_q.push_back({MOV_DIR, 16'h0800, 16'h0001});
    run_instr(1, 1'b1, 16'h0004, 16'h0004);

    // reset in the middle of FETCH_O, then a stray ack
    lat = 3;
    addr_q.push_back(16'h0004);
    r0 = req_rises;
    halt = 1'b0;
    @(negedge clk);
    halt = 1'b1;
    n = 0;
    while (req_rises < r0 + 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("fetch_o_reached", {31'h0, mem_req}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_req", {31'h0, mem_req}, 32'd0);
    check("midrst_pc", {16'h0, pc}, 32'd0);
    check("midrst_valid", {31'h0, instr_valid}, 32'd0);
    check("midrst_instruction", {16'h0, instruction}, 32'd0);
    reset_n = 1'b1;
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    check("late_ack_instruction", {16'h0, instruction}, 32'd0);
    check("late_ack_pc", {16'h0, pc}, 32'd0);
    check("late_ack_req", {31'h0, mem_req}, 32'd0);

    // memory never acknowledges
    ack_en = 1'b0;
    halt = 1'b0;
    @(negedge clk);
    halt = 1'b1;
`ifdef FETCH_TIMEOUT_EN
    repeat (TO - 1) @(negedge clk);
    check("to_last_req", {31'h0, mem_req}, 32'd1);
    check("to_no_fault_yet", {31'h0, fetch_fault}, 32'd0);
    @(negedge clk);
    check("to_fault", {31'h0, fetch_fault}, 32'd1);
    check("to_req_dropped", {31'h0, mem_req}, 32'd0);
    repeat (5) @(negedge clk);
    check("to_fault_sticky", {31'h0, fetch_fault}, 32'd1);
    check("to_valid_low", {31'h0, instr_valid}, 32'd0);
    check("to_no_req", {31'h0, mem_req}, 32'd0);
`else
    repeat (99) @(negedge clk);
    check("noto_still_req", {31'h0, mem_req}, 32'd1);
    check("noto_addr", {16'h0, mem_addr}, 32'd0);
    check("noto_fault", {31'h0, fetch_fault}, 32'd0);
`endif
    reset_n = 1'b0;
    @(negedge clk);
    check("final_rst_fault", {31'h0, fetch_fault}, 32'd0);
    check("final_rst_req", {31'h0, mem_req}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    check("addr_queue_drained", addr_q.size(), 32'd0);
    check("issue_queue_drained", iss_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
